hexacube_freq_meter: RTL and testbench
======================================

# hexacube_freq_meter

Measures the frequency of an external or on-board square wave (e.g. the divided display-refresh tick, or a pin under test) by counting rising edges over a fixed gate window derived from the 50 MHz board clock. It runs back-to-back windows with no dead time and publishes a saturating count plus a one-cycle valid strobe per window. It sits beside the clock dividers in the hexacube design and feeds the seven-segment display path.

## Interface
- `GATE_CYCLES`, 50_000_000: window length in `clk_50MHz` cycles; default is a 1 s gate, so the count is in Hz.
- `CNT_W`, 26: width of the edge counter and result.
- `GATE_W`, 26: width of the gate counter; must hold `GATE_CYCLES-1`.
- `clk_50MHz` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low. Asserting low clears all state immediately.
- `enable` in 1: synchronous; high runs continuous measurement.
- `sig_in` in 1: asynchronous input under measurement.
- `freq` out CNT_W: rising-edge count from the last completed window, saturating.
- `freq_valid` out 1: one-cycle strobe when `freq` is updated.
- `overflow` out 1: the last completed window saturated; held with `freq`.
- `busy` out 1: high while a window is open (state GATE).

## Operation
- Input path:
  - 2-FF synchronizer `s1` → `s2`, then delay register `s3`.
  - `rise = s2 & ~s3`.
  - All three registers reset to 0.
- States are IDLE and GATE.
- IDLE:
  - Gate counter and edge counter are 0.
  - `busy` = 0.
  - Next state is GATE when `enable` = 1.
- GATE, normal cycle:
  - `gate_ctr` increments by 1.
  - On `rise`, `edge_ctr` increments, saturating at 2^CNT_W−1.
  - A sticky `ovf_acc` is set when an increment is attempted at all-ones.
- GATE, terminal cycle (`gate_ctr == GATE_CYCLES-1`):
  - `freq` ← `edge_ctr` + `rise`, saturating.
  - `overflow` ← `ovf_acc` OR saturation on this cycle.
  - `freq_valid` ← 1 for one cycle.
  - `gate_ctr`, `edge_ctr` and `ovf_acc` clear.
  - State stays GATE if `enable` = 1, otherwise goes to IDLE.
  - A rise on the terminal cycle belongs to the closing window. Windows are contiguous, so each rise is counted exactly once.
- `enable` falling mid-window (not terminal cycle):
  - Abort to IDLE on the next edge.
  - Counters clear.
  - No `freq_valid`; `freq` and `overflow` hold their last values.
- Reset values:
  - `freq` = 0, `freq_valid` = 0, `overflow` = 0, `busy` = 0.
  - State IDLE; all counters and synchronizer flops 0.
- Reset mid-window discards the partial count. After reset deasserts, behaviour is as from power-up.

## Timing
- Entry: `enable` sampled high in IDLE at edge k puts the block in GATE from edge k.
- First strobe: `freq_valid` is high in the cycle after edge k+GATE_CYCLES. In steady state it repeats every GATE_CYCLES cycles.
- Edge latency: a `sig_in` rising edge appears as `rise` 2–3 cycles later (synchronizer).
- Input limits:
  - `sig_in` high and low phases must each be ≥ 2 clock periods (< 12.5 MHz) for an exact count.
  - Faster inputs undercount; this is not flagged.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `freq` is stable between strobes; the consumer may sample it at any time.

## Structure
- Shared header `hexacube_defs.vh`:
  - State encodings (`ST_IDLE`, `ST_GATE`).
  - Default `GATE_CYCLES_1S` = 50_000_000.
  - Board clock constant `CLK_HZ` = 50_000_000, shared with the divider blocks.
- Sub-module `sync_rise_det`:
  - 2-FF synchronizer, delay register and rise pulse.
  - Asynchronous active-low reset.
  - Reused by other hexacube inputs (buttons).
- The top module holds the FSM, both counters, the saturation logic and the output registers.

## Test plan
Simulation uses `GATE_CYCLES`=100 unless stated otherwise.
- **Steady count:** `enable`=1; `sig_in` period 10 cycles (5 high / 5 low) → `freq_valid` every 100 cycles; every window after the first reports `freq`=10, `overflow`=0; `busy`=1 throughout.
- **No edges:** `sig_in` held high → each strobe reports `freq`=0.
- **Saturation:**
  - `CNT_W`=4, `sig_in` period 4 → 25 edges; `freq`=15, `overflow`=1.
  - Then `sig_in` period 20 → next window `freq`=5, `overflow`=0.
- **Abort:** `enable` dropped at window cycle 50 → no strobe; `freq` holds its previous value; `busy`=0 next cycle. Re-enable → strobe exactly 100 cycles later.
- **Reset mid-window:** `reset` low at cycle 70 → `freq`, `overflow`, `freq_valid` and `busy` go to 0 immediately, without waiting for a clock edge. Release with `enable`=1 → first strobe 100 cycles after GATE entry, with no carried-over count.
- **Boundary edge:** `rise` aligned to the terminal cycle → counted in the closing window, not the next one. Total over 3 consecutive windows equals the total number of edges applied.

Source files
------------

// File: rtl/hexacube_freq_meter_pkg.sv
// Shared hexacube constants and FSM state type for the frequency meter.
// Board clock rate is also consumed by the divider blocks.
package hexacube_freq_meter_pkg;

   localparam int unsigned CLK_HZ         = 50_000_000;
   localparam int unsigned GATE_CYCLES_1S = CLK_HZ;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GATE = 1'b1
   } state_e;

endpackage

// File: rtl/hexacube_freq_meter_if.sv
// Control and result bundle between the frequency meter and its consumer.
// The meter is the slave side; the display path or bench is the master.
interface hexacube_freq_meter_if #(
   parameter int unsigned CNT_W = 26
);

   logic             enable;
   logic             sig_in;
   logic [CNT_W-1:0] freq;
   logic             freq_valid;
   logic             overflow;
   logic             busy;

   modport master (
      output enable,
      output sig_in,
      input  freq,
      input  freq_valid,
      input  overflow,
      input  busy
   );

   modport slave (
      input  enable,
      input  sig_in,
      output freq,
      output freq_valid,
      output overflow,
      output busy
   );

endinterface

// File: rtl/hexacube_freq_meter_sync_rise_det.sv
// Two-flop synchronizer plus delay stage producing a one-cycle rising-edge pulse.
// Also used for the hexacube push-button inputs.
module sync_rise_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;

   always_comb begin
      s1_d = d_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/hexacube_freq_meter.sv
// Gated edge counter: counts sig_in rising edges over back-to-back windows of
// GATE_CYCLES clocks and publishes a saturating result with a valid strobe.
module hexacube_freq_meter
   import hexacube_freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = GATE_CYCLES_1S,
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned GATE_W      = 26
) (
   input  logic                  clk_50MHz,
   input  logic                  reset,
   hexacube_freq_meter_if.slave  bus
);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_e             state_q, state_d;
   logic [GATE_W-1:0]  gate_ctr_q, gate_ctr_d;
   logic [CNT_W-1:0]   edge_ctr_q, edge_ctr_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic [CNT_W-1:0]   freq_q, freq_d;
   logic               freq_valid_q, freq_valid_d;
   logic               overflow_q, overflow_d;

   logic               rise;
   logic               terminal;
   logic               sat_now;
   logic [CNT_W-1:0]   edge_next;

   sync_rise_det u_sync (
      .clk   (clk_50MHz),
      .rst_n (reset),
      .d_in  (bus.sig_in),
      .rise  (rise)
   );

   assign terminal  = (gate_ctr_q == GATE_LAST);
   assign sat_now   = rise & (edge_ctr_q == CNT_MAX);
   assign edge_next = (rise && !sat_now) ? edge_ctr_q + CNT_W'(1) : edge_ctr_q;

   always_comb begin
      state_d      = state_q;
      gate_ctr_d   = gate_ctr_q;
      edge_ctr_d   = edge_ctr_q;
      ovf_acc_d    = ovf_acc_q;
      freq_d       = freq_q;
      overflow_d   = overflow_q;
      freq_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gate_ctr_d = '0;
            edge_ctr_d = '0;
            ovf_acc_d  = 1'b0;
            if (bus.enable) state_d = ST_GATE;
         end
         ST_GATE: begin
            // Terminal cycle wins over enable: a closing window always reports,
            // including any rise seen on this very cycle.
            if (terminal) begin
               freq_d       = edge_next;
               overflow_d   = ovf_acc_q | sat_now;
               freq_valid_d = 1'b1;
               gate_ctr_d   = '0;
               edge_ctr_d   = '0;
               ovf_acc_d    = 1'b0;
               state_d      = bus.enable ? ST_GATE : ST_IDLE;
            end else if (!bus.enable) begin
               gate_ctr_d = '0;
               edge_ctr_d = '0;
               ovf_acc_d  = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               gate_ctr_d = gate_ctr_q + GATE_W'(1);
               edge_ctr_d = edge_next;
               ovf_acc_d  = ovf_acc_q | sat_now;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         gate_ctr_q   <= '0;
         edge_ctr_q   <= '0;
         ovf_acc_q    <= 1'b0;
         freq_q       <= '0;
         freq_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         gate_ctr_q   <= gate_ctr_d;
         edge_ctr_q   <= edge_ctr_d;
         ovf_acc_q    <= ovf_acc_d;
         freq_q       <= freq_d;
         freq_valid_q <= freq_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.freq       = freq_q;
   assign bus.freq_valid = freq_valid_q;
   assign bus.overflow   = overflow_q;
   assign bus.busy       = (state_q == ST_GATE);

   a_strobe_single: assert property (@(posedge clk_50MHz) disable iff (!reset)
      freq_valid_q |=> !freq_valid_q);

   a_gate_bound: assert property (@(posedge clk_50MHz) disable iff (!reset)
      gate_ctr_q <= GATE_LAST);

endmodule

// File: tb/tb_hexacube_freq_meter.sv
// Self-checking bench for hexacube_freq_meter with a short gate and 4-bit counter.
module tb_hexacube_freq_meter;

   localparam int unsigned G    = 100;
   localparam int unsigned CW   = 4;
   localparam int          MAXV = 15;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   hexacube_freq_meter_if #(.CNT_W(CW)) bus ();

   hexacube_freq_meter #(
      .GATE_CYCLES (G),
      .CNT_W       (CW),
      .GATE_W      (7)
   ) dut (
      .clk_50MHz (clk),
      .reset     (reset),
      .bus       (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: rise is seen two clocks after sig_in is sampled high following a low sample.
   // A window is G cycles of GATE; its result is the plain edge total, clipped to MAXV.
   bit h1 = 0, h2 = 0, h3 = 0;
   bit m_busy = 0, m_valid = 0, m_ovf = 0;
   int m_freq = 0, m_total = 0, m_pos = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         h1 <= 0; h2 <= 0; h3 <= 0;
         m_busy <= 0; m_valid <= 0; m_ovf <= 0;
         m_freq <= 0; m_total <= 0; m_pos <= 0;
      end else begin
         int tot;
         tot = m_total + ((h2 && !h3) ? 1 : 0);
         m_valid <= 0;
         if (!m_busy) begin
            if (bus.enable) begin
               m_busy  <= 1;
               m_pos   <= 0;
               m_total <= 0;
            end
         end else if (m_pos == G - 1) begin
            m_freq  <= (tot > MAXV) ? MAXV : tot;
            m_ovf   <= (tot > MAXV);
            m_valid <= 1;
            m_busy  <= bus.enable;
            m_pos   <= 0;
            m_total <= 0;
         end else if (!bus.enable) begin
            m_busy <= 0;
         end else begin
            m_pos   <= m_pos + 1;
            m_total <= tot;
         end
         h1 <= bus.sig_in;
         h2 <= h1;
         h3 <= h2;
      end
   end

   int cyc = 0;
   int strobe_cnt = 0;
   int last_strobe_cyc = 0, prev_strobe_cyc = 0;
   int last_freq = 0;
   int last_ovf = 0;
   int strobe_q[$];

   always @(negedge clk) begin
      cyc++;
      check("freq",       int'(bus.freq),       m_freq);
      check("freq_valid", int'(bus.freq_valid), int'(m_valid));
      check("overflow",   int'(bus.overflow),   int'(m_ovf));
      check("busy",       int'(bus.busy),       int'(m_busy));
      if (bus.freq_valid) begin
         strobe_cnt++;
         prev_strobe_cyc = last_strobe_cyc;
         last_strobe_cyc = cyc;
         last_freq = int'(bus.freq);
         last_ovf  = int'(bus.overflow);
         strobe_q.push_back(int'(bus.freq));
      end
   end

   // sig_in generator: 0 level, 1 square wave of half-period sq_half, 2 random phases, 3 pattern
   int mode = 0;
   bit level = 0;
   int sq_half = 5;
   int ph_cnt = 0;
   int pidx = 0;
   bit pat[300];

   task automatic step();
      @(negedge clk);
      #1;
      case (mode)
         0: bus.sig_in = level;
         1: begin
            if (ph_cnt <= 0) begin
               bus.sig_in = ~bus.sig_in;
               ph_cnt = sq_half;
            end
            ph_cnt--;
         end
         2: begin
            if (ph_cnt <= 0) begin
               bus.sig_in = ~bus.sig_in;
               ph_cnt = int'($urandom_range(1, 6));
            end
            ph_cnt--;
         end
         default: begin
            bus.sig_in = (pidx < 300) ? pat[pidx] : 1'b0;
            pidx++;
         end
      endcase
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_strobe(input int limit, output int waited);
      int s0;
      s0 = strobe_cnt;
      waited = 0;
      while (strobe_cnt == s0 && waited < limit) begin
         step();
         waited++;
      end
      if (strobe_cnt == s0) check("strobe_timeout", 0, 1);
   endtask

   int w;
   int f0;
   int s0;
   int exp_edges;
   int seg_i, seg_len;
   bit seg_lvl, prev;

   initial begin
      bus.enable = 1'b0;
      bus.sig_in = 1'b0;

      run(3);
      check("reset_freq",     int'(bus.freq),       0);
      check("reset_valid",    int'(bus.freq_valid), 0);
      check("reset_overflow", int'(bus.overflow),   0);
      check("reset_busy",     int'(bus.busy),       0);
      reset = 1'b1;
      step();

      // steady 10-cycle square wave
      mode = 1; sq_half = 5; ph_cnt = 0;
      bus.enable = 1'b1;
      repeat (4) wait_strobe(120, w);
      check("steady_freq",   last_freq, 10);
      check("steady_ovf",    last_ovf, 0);
      check("steady_period", last_strobe_cyc - prev_strobe_cyc, 100);
      check("steady_busy",   int'(bus.busy), 1);

      // no edges
      mode = 0; level = 1'b1;
      repeat (3) wait_strobe(120, w);
      check("noedge_freq", last_freq, 0);

      // saturation: 25 edges into a 4-bit counter, then 5 edges
      mode = 1; sq_half = 2; ph_cnt = 0;
      repeat (3) wait_strobe(120, w);
      check("sat_freq", last_freq, 15);
      check("sat_ovf",  last_ovf, 1);
      sq_half = 10; ph_cnt = 0;
      repeat (3) wait_strobe(120, w);
      check("unsat_freq", last_freq, 5);
      check("unsat_ovf",  last_ovf, 0);

      // abort at window cycle 50, then re-enable
      wait_strobe(120, w);
      f0 = last_freq;
      run(50);
      bus.enable = 1'b0;
      step();
      check("abort_busy", int'(bus.busy), 0);
      s0 = strobe_cnt;
      run(150);
      check("abort_no_strobe", strobe_cnt - s0, 0);
      check("abort_freq_hold", int'(bus.freq), f0);
      bus.enable = 1'b1;
      wait_strobe(200, w);
      check("reenable_latency", w, 101);

      // asynchronous reset at window cycle 70
      run(70);
      check("pre_reset_freq", int'(bus.freq), 5);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_freq",     int'(bus.freq),       0);
      check("async_rst_overflow", int'(bus.overflow),   0);
      check("async_rst_valid",    int'(bus.freq_valid), 0);
      check("async_rst_busy",     int'(bus.busy),       0);
      run(2);
      reset = 1'b1;
      wait_strobe(200, w);
      check("post_reset_latency", w, 101);

      // boundary: pattern index i is driven in window cycle i+1 and rises in cycle i+3
      for (int i = 0; i < 300; i++) pat[i] = 1'b0;
      for (int i = 20; i <= 24; i++) pat[i] = 1'b1;
      for (int i = 96; i <= 102; i++) pat[i] = 1'b1;
      seg_i = 110;
      seg_lvl = 1'b0;
      while (seg_i < 260) begin
         seg_len = int'($urandom_range(4, 10));
         for (int j = 0; j < seg_len && seg_i < 260; j++) begin
            pat[seg_i] = seg_lvl;
            seg_i++;
         end
         seg_lvl = !seg_lvl;
      end
      exp_edges = 0;
      prev = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (pat[i] && !prev) exp_edges++;
         prev = pat[i];
      end
      mode = 0; level = 1'b0;
      repeat (2) wait_strobe(120, w);
      mode = 3; pidx = 0;
      strobe_q.delete();
      run(300);
      check("boundary_strobes", strobe_q.size(), 3);
      if (strobe_q.size() == 3) begin
         check("boundary_first_window", strobe_q[0], 2);
         check("boundary_total", strobe_q[0] + strobe_q[1] + strobe_q[2], exp_edges);
      end

      // random sig_in with random enable drops
      mode = 2; ph_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         run(int'($urandom_range(30, 250)));
         if ($urandom_range(0, 2) == 0) bus.enable = ~bus.enable;
         else bus.enable = 1'b1;
      end
      run(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
